// File: rtl/tangle_alu_pkg.sv
// rtl/tangle_alu_pkg.sv - opcodes, FSM states and helpers shared by the Tangle ALU
package tangle_alu_pkg;

  localparam logic [3:0] OP_OR    = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_NOT   = 4'd3;
  localparam logic [3:0] OP_NEG   = 4'd4;
  localparam logic [3:0] OP_ADD   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_CMP   = 4'd7;
  localparam logic [3:0] OP_MOV   = 4'd8;
  localparam logic [3:0] OP_MOVHI = 4'd9;
  localparam logic [3:0] OP_MOVLO = 4'd10;
  localparam logic [3:0] OP_SLL   = 4'd11;
  localparam logic [3:0] OP_SLR   = 4'd12;
  localparam logic [3:0] OP_SRA   = 4'd13;
  localparam logic [3:0] OP_ROL   = 4'd14;
  localparam logic [3:0] OP_MUL   = 4'd15;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // True for op classes that may iterate; shifts by zero still retire in one cycle.
  function automatic logic is_multicycle(input logic [3:0] op);
    return op inside {OP_SLL, OP_SLR, OP_SRA, OP_ROL, OP_MUL};
  endfunction

endpackage

// File: rtl/tangle_alu_seq_if.sv
// rtl/tangle_alu_seq_if.sv - issue/retire bundle between control unit and ALU
interface tangle_alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start_i;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] result_o;
  logic             zf_o;
  logic             sf_o;
  logic             cf_o;
  logic             of_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, op_i, data1_i, data2_i,
    input  result_o, zf_o, sf_o, cf_o, of_o, busy_o, done_o
  );

  modport slave (
    input  start_i, op_i, data1_i, data2_i,
    output result_o, zf_o, sf_o, cf_o, of_o, busy_o, done_o
  );
endinterface

// File: rtl/tangle_alu_seq_shifter.sv
// rtl/tangle_alu_seq_shifter.sv - iterative shift/rotate engine, also holds the MUL multiplier
module tangle_alu_seq_shifter
  import tangle_alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int STEP    = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [3:0]         op_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               fill_i,
  output logic               lsb_o,
  output logic [WIDTH-1:0]   data_nxt_o,
  output logic               cf_nxt_o,
  output logic               last_o
);
  localparam logic [SHAMT_W:0] STEP_R  = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] ONE_R   = (SHAMT_W+1)'(1);
  localparam logic [SHAMT_W:0] WIDTH_R = (SHAMT_W+1)'(WIDTH);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SHAMT_W:0] rem_q, rem_d, amt;
  logic [3:0]       op_q;
  logic             big;
  logic             cf_d;

  // MUL always walks one multiplier bit per cycle.
  assign big    = (op_q != OP_MUL) && (rem_q >= STEP_R);
  assign amt    = big ? STEP_R : ONE_R;
  assign rem_d  = rem_q - amt;
  assign last_o = (rem_d == '0);

  always_comb begin
    data_d = data_q;
    cf_d   = 1'b0;
    case (op_q)
      OP_SLL: begin
        if (big) begin
          data_d = {data_q[WIDTH-STEP-1:0], {STEP{1'b0}}};
          cf_d   = data_q[WIDTH-STEP];
        end else begin
          data_d = {data_q[WIDTH-2:0], 1'b0};
          cf_d   = data_q[WIDTH-1];
        end
      end
      OP_SLR: begin
        if (big) begin
          data_d = {{STEP{1'b0}}, data_q[WIDTH-1:STEP]};
          cf_d   = data_q[STEP-1];
        end else begin
          data_d = {1'b0, data_q[WIDTH-1:1]};
          cf_d   = data_q[0];
        end
      end
      OP_SRA: begin
        if (big) begin
          data_d = {{STEP{data_q[WIDTH-1]}}, data_q[WIDTH-1:STEP]};
          cf_d   = data_q[STEP-1];
        end else begin
          data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
          cf_d   = data_q[0];
        end
      end
      OP_ROL: begin
        if (big) begin
          data_d = {data_q[WIDTH-STEP-1:0], data_q[WIDTH-1:WIDTH-STEP]};
          cf_d   = data_q[WIDTH-STEP];
        end else begin
          data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          cf_d   = data_q[WIDTH-1];
        end
      end
      OP_MUL: data_d = {fill_i, data_q[WIDTH-1:1]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      rem_q  <= '0;
      op_q   <= OP_OR;
    end else if (load_i) begin
      data_q <= data_i;
      rem_q  <= (op_i == OP_MUL) ? WIDTH_R : {1'b0, shamt_i};
      op_q   <= op_i;
    end else if (step_i) begin
      data_q <= data_d;
      rem_q  <= rem_d;
    end
  end

  assign lsb_o      = data_q[0];
  assign data_nxt_o = data_d;
  assign cf_nxt_o   = cf_d;
endmodule

// File: rtl/tangle_alu_seq.sv
// rtl/tangle_alu_seq.sv - handshaked Tangle ALU with iterative shifter and shift-add multiply
module tangle_alu_seq
  import tangle_alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int STEP    = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  tangle_alu_seq_if.slave bus
);
  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, hi_q, hi_d, result_q, result_d;
  logic               zf_q, zf_d, sf_q, sf_d, cf_q, cf_d, of_q, of_d, done_q, done_d;
  logic [WIDTH-1:0]   opa, opb, sh_in, sh_nxt;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     wide, mul_sum;
  logic               issue, multi, sh_lsb, sh_cf, sh_last;

  assign opa   = bus.data1_i;
  assign opb   = bus.data2_i;
  assign shamt = opb[SHAMT_W-1:0];
  assign issue = bus.start_i && (state_q == S_IDLE);
  assign multi = is_multicycle(bus.op_i) && ((bus.op_i == OP_MUL) || (shamt != '0));
  // MUL keeps the multiplier in the shifter; the product's high half lives in hi_q.
  assign sh_in   = (bus.op_i == OP_MUL) ? opb : opa;
  assign mul_sum = {1'b0, hi_q} + (sh_lsb ? {1'b0, a_q} : '0);

  tangle_alu_seq_shifter #(
    .WIDTH   (WIDTH),
    .STEP    (STEP),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (issue && multi),
    .step_i     (state_q == S_RUN),
    .op_i       (bus.op_i),
    .data_i     (sh_in),
    .shamt_i    (shamt),
    .fill_i     (mul_sum[0]),
    .lsb_o      (sh_lsb),
    .data_nxt_o (sh_nxt),
    .cf_nxt_o   (sh_cf),
    .last_o     (sh_last)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    hi_d     = hi_q;
    result_d = result_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    cf_d     = cf_q;
    of_d     = of_q;
    done_d   = 1'b0;
    wide     = '0;
    case (state_q)
      S_IDLE: begin
        if (issue && multi) begin
          state_d = S_RUN;
          op_d    = bus.op_i;
          a_d     = opa;
          hi_d    = '0;
        end else if (issue) begin
          done_d = 1'b1;
          case (bus.op_i)
            OP_OR, OP_AND, OP_XOR, OP_SLL, OP_SLR, OP_SRA, OP_ROL: begin
              if (bus.op_i == OP_OR)       result_d = opa | opb;
              else if (bus.op_i == OP_AND) result_d = opa & opb;
              else if (bus.op_i == OP_XOR) result_d = opa ^ opb;
              else                         result_d = opa;
              zf_d = (result_d == '0);
              sf_d = result_d[WIDTH-1];
              cf_d = 1'b0;
              of_d = 1'b0;
            end
            OP_ADD, OP_SUB, OP_CMP: begin
              if (bus.op_i == OP_ADD) begin
                wide = {1'b0, opa} + {1'b0, opb};
                of_d = (opa[WIDTH-1] == opb[WIDTH-1]) && (wide[WIDTH-1] != opa[WIDTH-1]);
              end else begin
                wide = {1'b0, opa} - {1'b0, opb};
                of_d = (opa[WIDTH-1] != opb[WIDTH-1]) && (wide[WIDTH-1] != opa[WIDTH-1]);
              end
              if (bus.op_i != OP_CMP) result_d = wide[WIDTH-1:0];
              cf_d = wide[WIDTH];
              zf_d = (wide[WIDTH-1:0] == '0);
              sf_d = wide[WIDTH-1];
            end
            OP_NOT:   result_d = ~opa;
            OP_NEG:   result_d = '0 - opa;
            OP_MOV:   result_d = opb;
            OP_MOVHI: result_d = {opb[7:0], {(WIDTH-8){1'b0}}};
            OP_MOVLO: result_d = opa | opb;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (op_q == OP_MUL) hi_d = mul_sum[WIDTH:1];
        if (sh_last) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          result_d = sh_nxt;
          zf_d     = (sh_nxt == '0);
          sf_d     = sh_nxt[WIDTH-1];
          if (op_q == OP_MUL) begin
            cf_d = (mul_sum[WIDTH:1] != '0);
            of_d = cf_d;
          end else begin
            cf_d = sh_cf;
            of_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_OR;
      a_q      <= '0;
      hi_q     <= '0;
      result_q <= '0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      cf_q     <= cf_d;
      of_q     <= of_d;
      done_q   <= done_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.zf_o     = zf_q;
  assign bus.sf_o     = sf_q;
  assign bus.cf_o     = cf_q;
  assign bus.of_o     = of_q;
  assign bus.busy_o   = (state_q == S_RUN);
  assign bus.done_o   = done_q;
endmodule

// File: tb/tb_tangle_alu_seq.sv
// tb/tb_tangle_alu_seq.sv - directed and random checks of tangle_alu_seq against an arithmetic model
module tb_tangle_alu_seq;
  import tangle_alu_pkg::*;

  localparam int W    = 16;
  localparam int STEP = 4;
  localparam int SW   = $clog2(W);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tangle_alu_seq_if #(.WIDTH(W)) bus ();
  tangle_alu_seq #(.WIDTH(W), .STEP(STEP)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_res;
  logic exp_zf, exp_sf, exp_cf, exp_of;
  int exp_k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_res(input logic [W-1:0] r, input logic cf, input logic of, input bit wr);
    if (wr) exp_res = r;
    exp_zf = (r == '0);
    exp_sf = r[W-1];
    exp_cf = cf;
    exp_of = of;
  endtask

  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int s, sa, sb, sr;
    logic [2*W-1:0] p;
    logic [W-1:0] r;
    s  = int'(b[SW-1:0]);
    sa = int'($signed(a));
    sb = int'($signed(b));
    exp_k = 0;
    case (op)
      OP_OR:  set_res(a | b, 1'b0, 1'b0, 1'b1);
      OP_AND: set_res(a & b, 1'b0, 1'b0, 1'b1);
      OP_XOR: set_res(a ^ b, 1'b0, 1'b0, 1'b1);
      OP_ADD: begin
        sr = sa + sb;
        r  = a + b;
        set_res(r, (int'(a) + int'(b)) >= (1 << W),
                (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1))), 1'b1);
      end
      OP_SUB, OP_CMP: begin
        sr = sa - sb;
        r  = a - b;
        set_res(r, a < b, (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1))), op == OP_SUB);
      end
      OP_NOT:   exp_res = ~a;
      OP_NEG:   exp_res = -a;
      OP_MOV:   exp_res = b;
      OP_MOVHI: exp_res = b << (W - 8);
      OP_MOVLO: exp_res = a | b;
      OP_MUL: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        set_res(p[W-1:0], p[2*W-1:W] != '0, p[2*W-1:W] != '0, 1'b1);
        exp_k = W;
      end
      default: begin
        if (s == 0) begin
          set_res(a, 1'b0, 1'b0, 1'b1);
        end else begin
          exp_k = s / STEP + s % STEP;
          case (op)
            OP_SLL:  set_res(a << s, a[W-s], 1'b0, 1'b1);
            OP_SLR:  set_res(a >> s, a[s-1], 1'b0, 1'b1);
            OP_SRA: begin
              r = $signed(a) >>> s;
              set_res(r, a[s-1], 1'b0, 1'b1);
            end
            default: begin
              r = (a << s) | (a >> (W - s));
              set_res(r, r[0], 1'b0, 1'b1);
            end
          endcase
        end
      end
    endcase
  endtask

  // Entered and left on a falling edge so consecutive calls issue back-to-back.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke);
    int c, busy_cnt;
    bit seen;
    model_op(op, a, b);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.data1_i = a;
    bus.data2_i = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.op_i    = 4'($urandom);
    bus.data1_i = W'($urandom);
    bus.data2_i = W'($urandom);
    c = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && c < 40) begin
      @(negedge clk);
      c++;
      if (poke && c == 3) begin
        bus.start_i = 1'b1;
        bus.op_i    = OP_ADD;
      end else begin
        bus.start_i = 1'b0;
      end
      if (bus.done_o) seen = 1'b1;
      if (bus.busy_o) busy_cnt++;
    end
    check($sformatf("%s latency", tag), c, exp_k + 1);
    check($sformatf("%s busy", tag), busy_cnt, exp_k);
    check($sformatf("%s result", tag), bus.result_o, exp_res);
    check($sformatf("%s flags zscO", tag), {bus.zf_o, bus.sf_o, bus.cf_o, bus.of_o},
          {exp_zf, exp_sf, exp_cf, exp_of});
  endtask

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return W'(1) << (W - 1);
      3: return ~(W'(1) << (W - 1));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int done_cnt;
    logic [3:0] rop;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = OP_OR;
    bus.data1_i = '0;
    bus.data2_i = '0;
    repeat (3) @(negedge clk);
    check("reset state", {bus.result_o, bus.zf_o, bus.sf_o, bus.cf_o, bus.of_o, bus.busy_o, bus.done_o}, '0);
    rst = 1'b0;
    exp_res = '0;
    set_res('0, 1'b0, 1'b0, 1'b0);
    exp_zf = 1'b0;

    run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    run_op("not_keep", OP_NOT, 16'h00FF, 16'h1234, 1'b0);
    run_op("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 1'b0);
    run_op("cmp_eq",   OP_CMP, 16'h0005, 16'h0005, 1'b0);
    run_op("sll_15",   OP_SLL, 16'h0001, 16'h000F, 1'b0);
    run_op("sra_4",    OP_SRA, 16'h8000, 16'h0004, 1'b0);
    run_op("rol_1",    OP_ROL, 16'h8001, 16'h0001, 1'b0);
    run_op("slr_0",    OP_SLR, 16'hA5A5, 16'h0010, 1'b0);
    run_op("mul_hi",   OP_MUL, 16'h0100, 16'h0100, 1'b0);
    run_op("mul_3x7",  OP_MUL, 16'h0003, 16'h0007, 1'b0);
    run_op("mul_poke", OP_MUL, 16'h1234, 16'h0037, 1'b1);

    bus.start_i = 1'b1;
    bus.op_i    = OP_MUL;
    bus.data1_i = 16'h00FF;
    bus.data2_i = 16'h0101;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy", bus.busy_o, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort clear", {bus.result_o, bus.zf_o, bus.sf_o, bus.cf_o, bus.of_o, bus.busy_o, bus.done_o}, '0);
    exp_res = '0;
    set_res('0, 1'b0, 1'b0, 1'b0);
    exp_zf = 1'b0;
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done_o) done_cnt++;
    end
    check("abort no done", done_cnt, 0);
    run_op("add_after_rst", OP_ADD, 16'h0002, 16'h0002, 1'b0);

    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom);
      run_op($sformatf("rand%0d op%0d", i, rop), rop, rand_word(), rand_word(), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
